// File: rtl/move_player.sv
// Per-character movement: horizontal walking, gravity-driven vertical motion with
// terminal speed, screen clamping, jump edge detect, coyote time and jump buffering.
module move_player #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int V_W      = 6,
    parameter int H_STEP   = 1,
    parameter int GRAVITY  = 1,
    parameter int JUMP_V   = 6,
    parameter int MAX_FALL = 8,
    parameter int COYOTE   = 3,
    parameter int JBUF     = 3,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 100
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           respawn,
    input  logic [3:0]     wsad_down,
    input  logic [3:0]     collision_state,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic [V_W-1:0] v_y,
    output logic [2:0]     player_state,
    output logic [1:0]     mstate
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } mstate_t;

    localparam int C_W     = (COYOTE < 1) ? 1 : $clog2(COYOTE + 1);
    localparam int B_W     = (JBUF < 1) ? 1 : $clog2(JBUF + 1);
    localparam int FLOOR_I = -MAX_FALL;

    localparam logic [X_W:0]          STEP_X  = H_STEP[X_W:0];
    localparam logic [X_W:0]          XMAX_X  = X_MAX[X_W:0];
    localparam logic signed [Y_W+1:0] YMAX_Y  = Y_MAX[Y_W+1:0];
    localparam logic signed [V_W:0]   GRAV_V  = GRAVITY[V_W:0];
    localparam logic signed [V_W:0]   FLOOR_V = FLOOR_I[V_W:0];
    localparam logic [V_W-1:0]        JUMP_VV = JUMP_V[V_W-1:0];
    localparam logic [C_W-1:0]        COY_C   = COYOTE[C_W-1:0];
    localparam logic [B_W-1:0]        JBUF_C  = JBUF[B_W-1:0];

    mstate_t               state;
    logic [C_W-1:0]        coyote_cnt;
    logic [B_W-1:0]        jbuf_cnt;
    logic                  w_prev;
    logic                  jreq;
    logic [X_W:0]          x_ext;
    logic [X_W:0]          x_left;
    logic [X_W:0]          x_right;
    logic signed [Y_W+1:0] y_diff;
    logic [Y_W-1:0]        y_step;
    logic signed [V_W:0]   v_dec;
    logic [V_W-1:0]        v_fall;
    logic                  v_dec_le0;
    logic                  unused_s_key;

    assign unused_s_key = wsad_down[2];
    assign mstate       = state;
    assign jreq         = wsad_down[0] & ~w_prev;

    // One extra bit on x and two on y keep the step arithmetic from wrapping before clamping.
    always_comb begin
        x_ext   = {1'b0, x_pos};
        x_left  = (x_ext >= STEP_X) ? (x_ext - STEP_X) : '0;
        x_right = x_ext + STEP_X;
        if (x_right > XMAX_X) begin
            x_right = XMAX_X;
        end
        y_diff = $signed({2'b00, y_pos}) - $signed({{(Y_W + 2 - V_W){v_y[V_W-1]}}, v_y});
        if (y_diff[Y_W+1]) begin
            y_step = '0;
        end else if (y_diff > YMAX_Y) begin
            y_step = YMAX_Y[Y_W-1:0];
        end else begin
            y_step = y_diff[Y_W-1:0];
        end
        v_dec     = $signed({v_y[V_W-1], v_y}) - GRAV_V;
        v_fall    = (v_dec < FLOOR_V) ? FLOOR_V[V_W-1:0] : v_dec[V_W-1:0];
        v_dec_le0 = v_dec[V_W] || (v_dec == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || respawn) begin
            x_pos        <= INIT_X[X_W-1:0];
            y_pos        <= INIT_Y[Y_W-1:0];
            v_y          <= '0;
            state        <= FALL;
            player_state <= 3'b010;
            coyote_cnt   <= '0;
            jbuf_cnt     <= '0;
            w_prev       <= 1'b0;
        end else if (frame_tick) begin
            w_prev <= wsad_down[0];

            if (wsad_down[1]) begin
                player_state[0] <= 1'b0;
                player_state[2] <= 1'b1;
                if (!collision_state[3]) x_pos <= x_left[X_W-1:0];
            end else if (wsad_down[3]) begin
                player_state[0] <= 1'b1;
                player_state[2] <= 1'b1;
                if (!collision_state[2]) x_pos <= x_right[X_W-1:0];
            end else begin
                player_state[2] <= 1'b0;
            end

            case (state)
                GROUND: begin
                    if (jreq) begin
                        v_y             <= JUMP_VV;
                        state           <= RISE;
                        player_state[1] <= 1'b1;
                    end else if (!collision_state[0]) begin
                        v_y             <= '0;
                        state           <= FALL;
                        coyote_cnt      <= COY_C;
                        player_state[1] <= 1'b1;
                    end else begin
                        v_y             <= '0;
                        player_state[1] <= 1'b0;
                    end
                end
                RISE: begin
                    player_state[1] <= 1'b1;
                    // A ceiling hit outranks a simultaneous floor contact.
                    if (collision_state[1]) begin
                        v_y        <= '0;
                        state      <= FALL;
                        coyote_cnt <= '0;
                    end else begin
                        y_pos <= y_step;
                        v_y   <= v_dec[V_W-1:0];
                        if (v_dec_le0) state <= FALL;
                    end
                end
                FALL: begin
                    if (collision_state[0]) begin
                        jbuf_cnt <= '0;
                        if ((jbuf_cnt != '0) || jreq) begin
                            v_y             <= JUMP_VV;
                            state           <= RISE;
                            player_state[1] <= 1'b1;
                        end else begin
                            v_y             <= '0;
                            state           <= GROUND;
                            player_state[1] <= 1'b0;
                        end
                    end else if (jreq && (coyote_cnt != '0)) begin
                        v_y             <= JUMP_VV;
                        state           <= RISE;
                        coyote_cnt      <= '0;
                        player_state[1] <= 1'b1;
                    end else begin
                        y_pos           <= y_step;
                        v_y             <= v_fall;
                        player_state[1] <= 1'b1;
                        if (coyote_cnt != '0) coyote_cnt <= coyote_cnt - 1'b1;
                        if (jreq) begin
                            jbuf_cnt <= JBUF_C;
                        end else if (jbuf_cnt != '0) begin
                            jbuf_cnt <= jbuf_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= FALL;
                    player_state[1] <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_player.sv
// Directed bench for move_player: reset/idle hold, jump arc, terminal fall, coyote time,
// jump buffer, walls, x/y bounds and respawn, with hand-computed expectations.
module tb_move_player;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       respawn = 1'b0;
    logic [3:0] wsad_down = 4'b0000;
    logic [3:0] collision_state = 4'b0000;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic [5:0] v_y;
    logic [2:0] player_state;
    logic [1:0] mstate;

    logic       frame_tick2 = 1'b0;
    logic       respawn2 = 1'b0;
    logic [3:0] wsad2 = 4'b0000;
    logic [3:0] col2 = 4'b0000;
    logic [9:0] x_pos2;
    logic [8:0] y_pos2;
    logic [5:0] v_y2;
    logic [2:0] player_state2;
    logic [1:0] mstate2;

    int errors = 0;
    int checks = 0;
    int arc_y[6];
    int arc_v[6];

    always #5 clk = ~clk;

    move_player u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .respawn(respawn),
        .wsad_down(wsad_down), .collision_state(collision_state),
        .x_pos(x_pos), .y_pos(y_pos), .v_y(v_y),
        .player_state(player_state), .mstate(mstate)
    );

    move_player #(.H_STEP(2), .INIT_X(638)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick2), .respawn(respawn2),
        .wsad_down(wsad2), .collision_state(col2),
        .x_pos(x_pos2), .y_pos(y_pos2), .v_y(v_y2),
        .player_state(player_state2), .mstate(mstate2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int ey, input int ev,
                           input int ems, input int eps);
        chk({tag, ".x"}, int'(x_pos), ex);
        chk({tag, ".y"}, int'(y_pos), ey);
        chk({tag, ".v"}, int'($signed(v_y)), ev);
        chk({tag, ".mstate"}, int'(mstate), ems);
        chk({tag, ".pstate"}, int'(player_state), eps);
    endtask

    task automatic tick(input logic [3:0] keys, input logic [3:0] col);
        wsad_down       = keys;
        collision_state = col;
        frame_tick      = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic tick2(input logic [3:0] keys);
        wsad2       = keys;
        frame_tick2 = 1'b1;
        @(posedge clk);
        #1;
        frame_tick2 = 1'b0;
    endtask

    initial begin
        arc_y = '{194, 189, 185, 182, 180, 179};
        arc_v = '{5, 4, 3, 2, 1, 0};

        // reset and idle hold
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all("reset", 100, 100, 0, 2, 3'b010);
        wsad_down = 4'b1001;
        repeat (10) @(posedge clk);
        #1;
        chk_all("idle", 100, 100, 0, 2, 3'b010);
        wsad_down = 4'b0000;

        // right bound with H_STEP=2 from x=638
        chk("r_bound.init", int'(x_pos2), 638);
        tick2(4'b1000);
        chk("r_bound.step", int'(x_pos2), 639);
        tick2(4'b1000);
        chk("r_bound.hold", int'(x_pos2), 639);
        chk("r_bound.pstate", int'(player_state2), 3'b111);

        // terminal fall from v=0
        repeat (8) tick(4'b0000, 4'b0000);
        chk("fall8.y", int'(y_pos), 128);
        chk("fall8.v", int'($signed(v_y)), -8);
        repeat (4) tick(4'b0000, 4'b0000);
        chk_all("fall12", 100, 160, -8, 2, 3'b010);
        repeat (5) tick(4'b0000, 4'b0000);
        chk("fall17.y", int'(y_pos), 200);

        // land, then take off on a w edge
        tick(4'b0000, 4'b0001);
        chk_all("land200", 100, 200, 0, 0, 3'b000);
        tick(4'b0001, 4'b0001);
        chk_all("takeoff", 100, 200, 6, 1, 3'b010);
        for (int i = 0; i < 6; i++) begin
            tick(4'b0001, 4'b0000);
            chk($sformatf("arc%0d.y", i), int'(y_pos), arc_y[i]);
            chk($sformatf("arc%0d.v", i), int'($signed(v_y)), arc_v[i]);
            chk($sformatf("arc%0d.ms", i), int'(mstate), (i == 5) ? 2 : 1);
        end
        tick(4'b0001, 4'b0000);
        chk_all("hold_w", 100, 179, -1, 2, 3'b010);
        tick(4'b0001, 4'b0001);
        chk_all("land179", 100, 179, 0, 0, 3'b000);

        // coyote: jump accepted on 2nd tick after leaving ground
        tick(4'b0000, 4'b0001);
        tick(4'b0000, 4'b0000);
        chk_all("coy_drop", 100, 179, 0, 2, 3'b010);
        tick(4'b0000, 4'b0000);
        tick(4'b0001, 4'b0000);
        chk_all("coy_jump", 100, 179, 6, 1, 3'b010);
        tick(4'b0000, 4'b0011);
        chk_all("ceil_floor", 100, 179, 0, 2, 3'b010);
        tick(4'b0000, 4'b0001);
        chk("reland.ms", int'(mstate), 0);

        // coyote expired on 4th tick; that press then buffers into the landing
        tick(4'b0000, 4'b0000);
        repeat (3) tick(4'b0000, 4'b0000);
        tick(4'b0001, 4'b0000);
        chk_all("coy_late", 100, 185, -4, 2, 3'b010);
        tick(4'b0001, 4'b0000);
        tick(4'b0001, 4'b0001);
        chk_all("jbuf_hit", 100, 189, 6, 1, 3'b010);

        // press 5 ticks before landing: buffer expired
        tick(4'b0000, 4'b0010);
        chk_all("ceiling", 100, 189, 0, 2, 3'b010);
        repeat (5) tick(4'b0001, 4'b0000);
        chk("jbuf_old.y", int'(y_pos), 199);
        tick(4'b0001, 4'b0001);
        chk_all("jbuf_miss", 100, 199, 0, 0, 3'b000);

        // walls and key priority
        tick(4'b1000, 4'b0101);
        chk_all("wall_r", 100, 199, 0, 0, 3'b101);
        tick(4'b1000, 4'b0001);
        chk("d.x", int'(x_pos), 101);
        tick(4'b0010, 4'b0001);
        chk_all("a", 100, 199, 0, 0, 3'b100);
        tick(4'b1010, 4'b0001);
        chk_all("a_and_d", 99, 199, 0, 0, 3'b100);
        tick(4'b0010, 4'b1001);
        chk("wall_l.x", int'(x_pos), 99);
        tick(4'b1000, 4'b0001);
        tick(4'b0100, 4'b0001);
        chk_all("s_only", 100, 199, 0, 0, 3'b001);

        // left bound
        repeat (99) tick(4'b0010, 4'b0001);
        chk("l_bound.x1", int'(x_pos), 1);
        tick(4'b0010, 4'b0001);
        chk("l_bound.x0", int'(x_pos), 0);
        tick(4'b0010, 4'b0001);
        chk_all("l_bound.hold", 0, 199, 0, 0, 3'b100);

        // y clamp at bottom
        tick(4'b0000, 4'b0000);
        repeat (45) tick(4'b0000, 4'b0000);
        chk_all("y_clamp", 0, 479, -8, 2, 3'b010);

        // respawn mid-rise
        tick(4'b0000, 4'b0001);
        tick(4'b0001, 4'b0001);
        tick(4'b0001, 4'b0000);
        chk_all("rise479", 0, 473, 5, 1, 3'b010);
        respawn = 1'b1;
        @(posedge clk);
        #1;
        respawn = 1'b0;
        chk_all("respawn", 100, 100, 0, 2, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
